// File: rtl/clock_pkg.sv
// Shared types and default timing for the clock front panel: lane FSM states,
// 65.536 kHz timing defaults and key lane indices.
package clock_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } lane_state_t;

    localparam int unsigned DB_CYCLES_20MS = 1311;
    localparam int unsigned LONG_1S        = 65536;
    localparam int unsigned REPEAT_250MS   = 16384;

    localparam int unsigned KEY_MODE = 0;
    localparam int unsigned KEY_ADD  = 1;

endpackage

// File: rtl/key_debounce_lane.sv
// One key lane: 2-flop synchroniser, debounce counter, and RELEASED/PRESSED/HELD
// FSM producing registered press, release, long-press and auto-repeat pulses.
module key_debounce_lane
    import clock_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW    = 0,
    parameter int unsigned DB_CYCLES     = DB_CYCLES_20MS,
    parameter int unsigned LONG_CYCLES   = LONG_1S,
    parameter int unsigned REPEAT_CYCLES = REPEAT_250MS,
    parameter bit          REPEAT_EN     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_down,
    output logic key_up,
    output logic key_long,
    output logic key_repeat
);

    localparam int unsigned DB_W   = (DB_CYCLES > 1)     ? $clog2(DB_CYCLES)     : 1;
    localparam int unsigned HOLD_W = (LONG_CYCLES > 1)   ? $clog2(LONG_CYCLES)   : 1;
    localparam int unsigned REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic              raw_c;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_q, db_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              down_q, down_d, up_q, up_d, long_q, long_d, rpt_q, rpt_d;
    logic              accept_c, press_c, release_c, long_hit_c, rep_hit_c;
    lane_state_t       state_q, state_d;

    assign raw_c = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    // Debounce: accept a level change after DB_CYCLES consecutive differing samples.
    always_comb begin
        sync1_d  = raw_c;
        sync2_d  = sync1_q;
        db_d     = db_q;
        level_d  = level_q;
        accept_c = 1'b0;
        if (sync2_q == level_q) begin
            db_d = '0;
        end else if (db_q == DB_W'(DB_CYCLES - 1)) begin
            db_d     = '0;
            level_d  = ~level_q;
            accept_c = 1'b1;
        end else begin
            db_d = db_q + DB_W'(1);
        end
    end

    assign press_c    = accept_c &  sync2_q;
    assign release_c  = accept_c & ~sync2_q;
    assign long_hit_c = (hold_q == HOLD_W'(LONG_CYCLES - 1));
    assign rep_hit_c  = (rep_q == REP_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RELEASED: if (press_c) state_d = PRESSED;
            PRESSED: begin
                if (release_c)       state_d = RELEASED;
                else if (long_hit_c) state_d = HELD;
            end
            HELD:     if (release_c) state_d = RELEASED;
            default:  state_d = RELEASED;
        endcase
    end

    // Counters and pulses; an accepted release masks a coincident long/repeat tick.
    always_comb begin
        hold_d = '0;
        rep_d  = '0;
        down_d = 1'b0;
        up_d   = 1'b0;
        long_d = 1'b0;
        rpt_d  = 1'b0;
        case (state_q)
            RELEASED: down_d = press_c;
            PRESSED: begin
                up_d = release_c;
                if (!release_c) begin
                    long_d = long_hit_c;
                    hold_d = long_hit_c ? '0 : hold_q + HOLD_W'(1);
                end
            end
            HELD: begin
                up_d = release_c;
                if (!release_c && REPEAT_EN) begin
                    rpt_d = rep_hit_c;
                    rep_d = rep_hit_c ? '0 : rep_q + REP_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            db_q    <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
            down_q  <= 1'b0;
            up_q    <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            db_q    <= db_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            down_q  <= down_d;
            up_q    <= up_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
        end
    end

    assign key_level  = level_q;
    assign key_down   = down_q;
    assign key_up     = up_q;
    assign key_long   = long_q;
    assign key_repeat = rpt_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button front end: NUM_KEYS independent debounced lanes emitting
// press/release/long/repeat pulses for the clock mode and time-set logic.
module key_debounce
    import clock_pkg::*;
#(
    parameter int unsigned          NUM_KEYS      = 2,
    parameter int unsigned          ACTIVE_LOW    = 0,
    parameter int unsigned          DB_CYCLES     = DB_CYCLES_20MS,
    parameter int unsigned          LONG_CYCLES   = LONG_1S,
    parameter int unsigned          REPEAT_CYCLES = REPEAT_250MS,
    parameter logic [NUM_KEYS-1:0]  REPEAT_MASK   = NUM_KEYS'(1 << KEY_ADD)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_up,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        key_debounce_lane #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .key_raw    (key_raw[i]),
            .key_level  (key_level[i]),
            .key_down   (key_down[i]),
            .key_up     (key_up[i]),
            .key_long   (key_long[i]),
            .key_repeat (key_repeat[i])
        );
    end

endmodule
